// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM sequence controller and its neighbours.
package lstm_pkg;

  typedef enum logic [1:0] {I, F, G, O} gate_t;

  typedef enum logic [1:0] {WX, WH, BX, BH} cfg_kind_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StDrain,
    StAbort
  } seq_state_t;

  localparam int unsigned CELL_LATENCY = 6;

  function automatic logic [3:0] gate_onehot(gate_t g);
    return 4'b0001 << g;
  endfunction

endpackage

// File: rtl/lstm_seq_ctrl.sv
// Sequence controller for the single-step LSTM cell: forwards configuration, loads initial
// state, issues one sample per step and buffers each result in a one-entry output register.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEQ_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [1:0]            cfg_kind_i,
  input  logic [1:0]            cfg_gate_i,
  input  logic [WIDTH-1:0]      cfg_data_i,

  input  logic                  start_i,
  input  logic [SEQ_W-1:0]      seq_len_i,
  input  logic [WIDTH-1:0]      h0_i,
  input  logic [WIDTH-1:0]      c0_i,
  input  logic                  abort_i,

  input  logic                  x_valid_i,
  output logic                  x_ready_o,
  input  logic [WIDTH-1:0]      x_data_i,

  output logic                  y_valid_o,
  input  logic                  y_ready_i,
  output logic [WIDTH-1:0]      y_data_o,
  output logic                  y_last_o,

  output logic                  done_o,
  output logic [WIDTH-1:0]      final_c_o,
  output logic                  busy_o,
  output logic [SEQ_W-1:0]      step_cnt_o,

  output logic [3:0][WIDTH-1:0] cell_weight_x_o,
  output logic [3:0][WIDTH-1:0] cell_weight_h_o,
  output logic [3:0][WIDTH-1:0] cell_bias_x_o,
  output logic [3:0][WIDTH-1:0] cell_bias_h_o,
  output logic [3:0]            cell_weight_x_valid_o,
  output logic [3:0]            cell_weight_h_valid_o,
  output logic [3:0]            cell_bias_x_valid_o,
  output logic [3:0]            cell_bias_h_valid_o,

  output logic [WIDTH-1:0]      cell_h_in_o,
  output logic [WIDTH-1:0]      cell_c_in_o,
  output logic [WIDTH-1:0]      cell_x_in_o,
  output logic                  cell_h_in_valid_o,
  output logic                  cell_c_in_valid_o,
  output logic                  cell_x_in_valid_o,

  input  logic                  cell_ready_i,
  input  logic                  cell_valid_i,
  input  logic [WIDTH-1:0]      cell_y_out_i,
  input  logic [WIDTH-1:0]      cell_c_out_i
);

  seq_state_t       state_q, state_d;
  logic [SEQ_W-1:0] n_q, n_d;
  logic [SEQ_W-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] h0_q, h0_d;
  logic [WIDTH-1:0] c0_q, c0_d;
  logic [WIDTH-1:0] last_c_q, last_c_d;
  logic [WIDTH-1:0] final_c_q, final_c_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;
  logic             done_q, done_d;

  logic             cfg_hs;
  logic             x_hs;
  logic             y_hs;
  logic             in_load;
  logic [SEQ_W-1:0] step_inc;
  logic             step_is_last;

  assign cfg_ready_o = (state_q == StIdle) && cell_ready_i && !rst_i;
  assign cfg_hs      = cfg_valid_i && cfg_ready_o;

  // Never issue while the output register is full, so a cell result always has a home.
  assign x_ready_o = (state_q == StIssue) && cell_ready_i && !y_valid_q && !abort_i && !rst_i;
  assign x_hs      = x_valid_i && x_ready_o;
  assign y_hs      = y_valid_q && y_ready_i;

  assign in_load      = (state_q == StLoad);
  assign step_inc     = step_cnt_q + SEQ_W'(1);
  assign step_is_last = (step_inc == n_q);

  assign cell_h_in_valid_o = in_load;
  assign cell_c_in_valid_o = in_load;
  assign cell_h_in_o       = in_load ? h0_q : '0;
  assign cell_c_in_o       = in_load ? c0_q : '0;
  assign cell_x_in_valid_o = x_hs;
  assign cell_x_in_o       = x_hs ? x_data_i : '0;

  assign y_valid_o  = y_valid_q;
  assign y_data_o   = y_data_q;
  assign y_last_o   = y_last_q;
  assign done_o     = done_q;
  assign final_c_o  = final_c_q;
  assign busy_o     = (state_q != StIdle);
  assign step_cnt_o = step_cnt_q;

  // Config writes broadcast the value on every lane; the one-hot valid selects the gate.
  always_comb begin
    cell_weight_x_o       = '0;
    cell_weight_h_o       = '0;
    cell_bias_x_o         = '0;
    cell_bias_h_o         = '0;
    cell_weight_x_valid_o = '0;
    cell_weight_h_valid_o = '0;
    cell_bias_x_valid_o   = '0;
    cell_bias_h_valid_o   = '0;
    if (cfg_hs) begin
      unique case (cfg_kind_t'(cfg_kind_i))
        WX: begin
          cell_weight_x_o       = {4{cfg_data_i}};
          cell_weight_x_valid_o = gate_onehot(gate_t'(cfg_gate_i));
        end
        WH: begin
          cell_weight_h_o       = {4{cfg_data_i}};
          cell_weight_h_valid_o = gate_onehot(gate_t'(cfg_gate_i));
        end
        BX: begin
          cell_bias_x_o       = {4{cfg_data_i}};
          cell_bias_x_valid_o = gate_onehot(gate_t'(cfg_gate_i));
        end
        BH: begin
          cell_bias_h_o       = {4{cfg_data_i}};
          cell_bias_h_valid_o = gate_onehot(gate_t'(cfg_gate_i));
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    step_cnt_d = step_cnt_q;
    h0_d       = h0_q;
    c0_d       = c0_q;
    last_c_d   = last_c_q;
    final_c_d  = final_c_q;
    y_data_d   = y_data_q;
    y_valid_d  = y_valid_q;
    y_last_d   = y_last_q;
    done_d     = 1'b0;

    if (y_hs) begin
      y_valid_d = 1'b0;
      y_last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          n_d  = seq_len_i;
          h0_d = h0_i;
          c0_d = c0_i;
          if (seq_len_i == '0) begin
            done_d    = 1'b1;
            final_c_d = c0_i;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        step_cnt_d = '0;
        if (abort_i) begin
          state_d   = StIdle;
          y_valid_d = 1'b0;
          y_last_d  = 1'b0;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (abort_i) begin
          state_d   = StIdle;
          y_valid_d = 1'b0;
          y_last_d  = 1'b0;
        end else if (x_hs) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (cell_valid_i && abort_i) begin
          // Result and abort coincide: drop the result, nothing left in flight.
          state_d = StIdle;
        end else if (cell_valid_i) begin
          y_data_d   = cell_y_out_i;
          y_valid_d  = 1'b1;
          y_last_d   = step_is_last;
          last_c_d   = cell_c_out_i;
          step_cnt_d = step_inc;
          state_d    = step_is_last ? StDrain : StIssue;
        end else if (abort_i) begin
          state_d = StAbort;
        end
      end
      StDrain: begin
        if (abort_i) begin
          state_d   = StIdle;
          y_valid_d = 1'b0;
          y_last_d  = 1'b0;
        end else if (y_hs) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          final_c_d = last_c_q;
        end
      end
      StAbort: begin
        if (cell_valid_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      n_q        <= '0;
      step_cnt_q <= '0;
      h0_q       <= '0;
      c0_q       <= '0;
      last_c_q   <= '0;
      final_c_q  <= '0;
      y_data_q   <= '0;
      y_valid_q  <= 1'b0;
      y_last_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      step_cnt_q <= step_cnt_d;
      h0_q       <= h0_d;
      c0_q       <= c0_d;
      last_c_q   <= last_c_d;
      final_c_q  <= final_c_d;
      y_data_q   <= y_data_d;
      y_valid_q  <= y_valid_d;
      y_last_q   <= y_last_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl with a fixed-latency behavioural cell and a result scoreboard.
module tb_lstm_seq_ctrl;

  localparam int W = 16;
  localparam int S = 8;

  logic              clk;
  logic              rst;
  logic              cfg_valid, cfg_ready;
  logic [1:0]        cfg_kind, cfg_gate;
  logic [W-1:0]      cfg_data;
  logic              start;
  logic [S-1:0]      seq_len;
  logic [W-1:0]      h0, c0;
  logic              abort;
  logic              x_valid, x_ready;
  logic [W-1:0]      x_data;
  logic              y_valid, y_ready, y_last;
  logic [W-1:0]      y_data;
  logic              done, busy;
  logic [W-1:0]      final_c;
  logic [S-1:0]      step_cnt;
  logic [3:0][W-1:0] wx, wh, bx, bh;
  logic [3:0]        wxv, whv, bxv, bhv;
  logic [W-1:0]      h_in, c_in, x_in;
  logic              h_in_v, c_in_v, x_in_v;
  logic              cell_ready, cell_valid;
  logic [W-1:0]      cell_y, cell_c;

  logic [15:0] cfg_v_all;
  logic [18:0] cell_v_all;
  assign cfg_v_all  = {wxv, whv, bxv, bhv};
  assign cell_v_all = {wxv, whv, bxv, bhv, h_in_v, c_in_v, x_in_v};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         last;
  } exp_t;
  exp_t sb[$];

  lstm_seq_ctrl #(.WIDTH(W), .SEQ_W(S)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_kind_i(cfg_kind),
    .cfg_gate_i(cfg_gate), .cfg_data_i(cfg_data),
    .start_i(start), .seq_len_i(seq_len), .h0_i(h0), .c0_i(c0), .abort_i(abort),
    .x_valid_i(x_valid), .x_ready_o(x_ready), .x_data_i(x_data),
    .y_valid_o(y_valid), .y_ready_i(y_ready), .y_data_o(y_data), .y_last_o(y_last),
    .done_o(done), .final_c_o(final_c), .busy_o(busy), .step_cnt_o(step_cnt),
    .cell_weight_x_o(wx), .cell_weight_h_o(wh), .cell_bias_x_o(bx), .cell_bias_h_o(bh),
    .cell_weight_x_valid_o(wxv), .cell_weight_h_valid_o(whv),
    .cell_bias_x_valid_o(bxv), .cell_bias_h_valid_o(bhv),
    .cell_h_in_o(h_in), .cell_c_in_o(c_in), .cell_x_in_o(x_in),
    .cell_h_in_valid_o(h_in_v), .cell_c_in_valid_o(c_in_v), .cell_x_in_valid_o(x_in_v),
    .cell_ready_i(cell_ready), .cell_valid_i(cell_valid),
    .cell_y_out_i(cell_y), .cell_c_out_i(cell_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] cy(input logic [W-1:0] x);
    return x + 16'h0101;
  endfunction

  function automatic logic [W-1:0] cc(input logic [W-1:0] x);
    return x ^ 16'h0ff0;
  endfunction

  // Behavioural cell: result appears CELL_LATENCY cycles after the issue cycle.
  logic         pend;
  int           lat;
  logic [W-1:0] px;
  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0; lat <= 0; px <= '0;
      cell_valid <= 1'b0; cell_ready <= 1'b1; cell_y <= '0; cell_c <= '0;
    end else begin
      cell_valid <= 1'b0;
      if (x_in_v) begin
        pend <= 1'b1; lat <= 1; px <= x_in; cell_ready <= 1'b0;
      end else if (pend) begin
        if (lat == int'(lstm_pkg::CELL_LATENCY) - 1) begin
          cell_valid <= 1'b1; cell_y <= cy(px); cell_c <= cc(px); pend <= 1'b0;
        end
        lat <= lat + 1;
      end
      if (cell_valid) cell_ready <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic y_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && y_valid && y_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL y_unexpected: got y_data=%h y_last=%b, required no output", y_data, y_last);
        end else begin
          e = sb.pop_front();
          if (y_data !== e.d || y_last !== e.last) begin
            n_fail++;
            $display("FAIL y_result: got y_data=%h y_last=%b, required y_data=%h y_last=%b",
                     y_data, y_last, e.d, e.last);
          end
        end
      end
    end
  endtask

  task automatic send_x(input logic [W-1:0] x, input bit push, input bit last, output time t);
    bit   hs;
    exp_t e;
    hs = 0;
    t = 0;
    x_valid = 1'b1;
    x_data = x;
    for (int c = 0; c < 200 && !hs; c++) begin
      #1;
      if (x_ready) begin
        hs = 1;
        t = $time;
        n_checks++;
        if (x_in_v !== 1'b1 || x_in !== x) begin
          n_fail++;
          $display("FAIL x_issue: got valid=%b data=%h, required valid=1 data=%h", x_in_v, x_in, x);
        end
        if (push) begin
          e.d = cy(x);
          e.last = last;
          sb.push_back(e);
        end
      end
      tick();
    end
    x_valid = 1'b0;
    x_data = '0;
    n_checks++;
    if (!hs) begin
      n_fail++;
      $display("FAIL x_timeout: got no x handshake, required one within 200 cycles");
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (done === 1'b1) got = 1;
      else tick();
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: got no done pulse, required one within 200 cycles");
    end
  endtask

  task automatic wait_y_valid();
    bit got;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (y_valid === 1'b1) got = 1;
      else tick();
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL y_valid_timeout: got y_valid=0, required 1 within 50 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (cfg_ready !== 1'b0 || x_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got cfg_ready=%b x_ready=%b, required 0 0", cfg_ready, x_ready);
    end
    n_checks++;
    if ({busy, y_valid, y_last, done, final_c, step_cnt, y_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b y_valid=%b done=%b final_c=%h step_cnt=%0d, required 0",
               busy, y_valid, done, final_c, step_cnt);
    end
    n_checks++;
    if (cell_v_all !== '0 || {h_in, c_in, x_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_cell: got valids=%b, required 0", cell_v_all);
    end
    cfg_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cfg();
    logic [1:0]   kinds [4];
    logic [1:0]   gates [4];
    logic [W-1:0] datas [4];
    logic [15:0]  ev;
    logic [3:0][W-1:0] bus;
    kinds = '{2'd0, 2'd3, 2'd1, 2'd2};
    gates = '{2'd2, 2'd0, 2'd3, 2'd1};
    datas = '{16'h0100, 16'h8001, 16'h7fff, 16'h1234};
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_kind = kinds[i];
      cfg_gate = gates[i];
      cfg_data = datas[i];
      #1;
      ev = '0;
      ev[4 * (3 - int'(kinds[i])) + int'(gates[i])] = 1'b1;
      case (kinds[i])
        2'd0: bus = wx;
        2'd1: bus = wh;
        2'd2: bus = bx;
        default: bus = bh;
      endcase
      n_checks++;
      if (cfg_ready !== 1'b1 || cfg_v_all !== ev) begin
        n_fail++;
        $display("FAIL cfg_valids[%0d]: got ready=%b valids=%b, required ready=1 valids=%b",
                 i, cfg_ready, cfg_v_all, ev);
      end
      n_checks++;
      if (bus !== {4{datas[i]}}) begin
        n_fail++;
        $display("FAIL cfg_lanes[%0d]: got %h, required all lanes %h", i, bus, datas[i]);
      end
      tick();
      cfg_valid = 1'b0;
      #1;
      n_checks++;
      if (cfg_v_all !== '0) begin
        n_fail++;
        $display("FAIL cfg_idle[%0d]: got valids=%b, required 0", i, cfg_v_all);
      end
      tick();
    end
  endtask

  task automatic test_seq3();
    logic [W-1:0] xs [3];
    time t, t_prev;
    xs = '{16'h0100, 16'h0080, 16'hff80};
    y_ready = 1'b1;
    start = 1'b1; seq_len = 8'd3; h0 = 16'h0000; c0 = 16'h0040;
    cfg_valid = 1'b1; cfg_kind = 2'd2; cfg_gate = 2'd1; cfg_data = 16'h0055;
    #1;
    n_checks++;
    if (bxv !== 4'b0010 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_with_start: got bias_x_valid=%b ready=%b, required 0010 1", bxv, cfg_ready);
    end
    tick();
    start = 1'b0;
    cfg_valid = 1'b0;
    n_checks++;
    if ({h_in_v, c_in_v} !== 2'b11 || h_in !== 16'h0000 || c_in !== 16'h0040 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load: got hv=%b cv=%b h=%h c=%h busy=%b, required 1 1 0000 0040 1",
               h_in_v, c_in_v, h_in, c_in, busy);
    end
    tick();
    n_checks++;
    if ({h_in_v, c_in_v} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_once: got hv=%b cv=%b, required 0 0", h_in_v, c_in_v);
    end
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      send_x(xs[i], 1'b1, i == 2, t);
      if (i > 0) begin
        n_checks++;
        if (t - t_prev < 70) begin
          n_fail++;
          $display("FAIL issue_spacing[%0d]: got %0t, required at least 70", i, t - t_prev);
        end
      end
      t_prev = t;
    end
    wait_done();
    n_checks++;
    if (final_c !== cc(16'hff80) || step_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL seq3_end: got final_c=%h step_cnt=%0d, required %h 3",
               final_c, step_cnt, cc(16'hff80));
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL seq3_pulse: got done=%b busy=%b pending=%0d, required 0 0 0",
               done, busy, sb.size());
    end
  endtask

  task automatic test_backpressure();
    time t;
    int  held_bad, issue_bad;
    y_ready = 1'b0;
    start = 1'b1; seq_len = 8'd2; h0 = 16'h0010; c0 = 16'h0000;
    tick();
    start = 1'b0;
    tick();
    send_x(16'h0200, 1'b1, 1'b0, t);
    wait_y_valid();
    x_valid = 1'b1;
    x_data = 16'h0300;
    held_bad = 0;
    issue_bad = 0;
    repeat (20) begin
      #1;
      if (y_valid !== 1'b1 || y_data !== cy(16'h0200)) held_bad++;
      if (x_ready !== 1'b0 || x_in_v !== 1'b0) issue_bad++;
      tick();
    end
    n_checks++;
    if (held_bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d cycles with y changed, required 0", held_bad);
    end
    n_checks++;
    if (issue_bad != 0) begin
      n_fail++;
      $display("FAIL bp_issue: got %0d cycles with an issue, required 0", issue_bad);
    end
    y_ready = 1'b1;
    send_x(16'h0300, 1'b1, 1'b1, t);
    wait_done();
    n_checks++;
    if (final_c !== cc(16'h0300) || step_cnt !== 8'd2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_end: got final_c=%h step_cnt=%0d pending=%0d, required %h 2 0",
               final_c, step_cnt, sb.size(), cc(16'h0300));
    end
    tick();
  endtask

  task automatic test_zero_len();
    y_ready = 1'b1;
    start = 1'b1; seq_len = 8'd0; h0 = 16'h5555; c0 = 16'h1234;
    #1;
    n_checks++;
    if (cell_v_all !== '0) begin
      n_fail++;
      $display("FAIL zero_start_cell: got valids=%b, required 0", cell_v_all);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || final_c !== 16'h1234 || busy !== 1'b0 || cell_v_all !== '0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b final_c=%h busy=%b valids=%b, required 1 1234 0 0",
               done, final_c, busy, cell_v_all);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || final_c !== 16'h1234) begin
      n_fail++;
      $display("FAIL zero_hold: got done=%b final_c=%h, required 0 1234", done, final_c);
    end
  endtask

  task automatic test_abort();
    time t;
    bit  saw;
    int  bad;
    y_ready = 1'b1;
    start = 1'b1; seq_len = 8'd2; h0 = 16'h0000; c0 = 16'h0000;
    tick();
    start = 1'b0;
    tick();
    send_x(16'h0400, 1'b0, 1'b0, t);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    saw = 0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (y_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) bad++;
      if (cell_valid === 1'b1) begin
        saw = 1;
        tick();
        break;
      end
      tick();
    end
    n_checks++;
    if (!saw || bad != 0) begin
      n_fail++;
      $display("FAIL abort_wait: got saw_cell_valid=%b bad_cycles=%0d, required 1 0", saw, bad);
    end
    n_checks++;
    if (busy !== 1'b0 || y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b y_valid=%b, required 0 0", busy, y_valid);
    end
    bad = 0;
    repeat (4) begin
      if (done !== 1'b0 || y_valid !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d cycles with done or y_valid, required 0", bad);
    end
  endtask

  task automatic test_rst_mid();
    time t;
    y_ready = 1'b0;
    start = 1'b1; seq_len = 8'd4; h0 = 16'h0100; c0 = 16'h0200;
    tick();
    start = 1'b0;
    tick();
    send_x(16'h0500, 1'b1, 1'b0, t);
    wait_y_valid();
    n_checks++;
    if (step_cnt !== 8'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: got step_cnt=%0d busy=%b, required 1 1", step_cnt, busy);
    end
    rst = 1'b1;
    cfg_valid = 1'b1;
    x_valid = 1'b1;
    tick();
    n_checks++;
    if ({busy, y_valid, y_last, done, final_c, step_cnt, y_data} !== '0 ||
        cfg_ready !== 1'b0 || x_ready !== 1'b0 || cell_v_all !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got busy=%b y_valid=%b y_data=%h final_c=%h step_cnt=%0d valids=%b, required 0",
               busy, y_valid, y_data, final_c, step_cnt, cell_v_all);
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    x_valid = 1'b0;
    sb.delete();
    y_ready = 1'b1;
    tick();
    start = 1'b1; seq_len = 8'd1; h0 = 16'h0000; c0 = 16'h0007;
    tick();
    start = 1'b0;
    tick();
    send_x(16'h0600, 1'b1, 1'b1, t);
    wait_done();
    n_checks++;
    if (final_c !== cc(16'h0600) || step_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL post_rst_seq: got final_c=%h step_cnt=%0d, required %h 1",
               final_c, step_cnt, cc(16'h0600));
    end
    tick();
    n_checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_drain: got pending=%0d busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_kind = '0; cfg_gate = '0; cfg_data = '0;
    start = 1'b0; seq_len = '0; h0 = '0; c0 = '0; abort = 1'b0;
    x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
    fork
      y_monitor();
      begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
        $fatal(1);
      end
    join_none
    test_reset();
    test_cfg();
    test_seq3();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
